axis_pkt_rr_arbiter: RTL

- Packet-granular round-robin arbiter that merges NUM_IN AXI-Stream packet pipelines onto one master AXI-Stream toward the output queues.
- Each input is the output stream of one packet-processing pipeline.
- A grant is held from the first beat to the tlast beat, so packets are never interleaved.
- Output data path is a zero-latency mux of the granted input. Only the grant/state logic is registered.

---
 rtl/axis_pkt_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/axis_pkt_rr_arbiter.sv
// axis_pkt_rr_arbiter: packet-granular round-robin merge of NUM_IN AXI-Stream
// inputs onto one master stream. The grant is held from first beat to tlast,
// the data path is a zero-latency mux, and the first beat of every packet gets
// its source port stamped one-hot into tuser[23:16].
// Optional feature: define ARB_PKT_CNT_EN to build per-input 32-bit packet
// counters on pkt_cnt; without it pkt_cnt is tied to zero.
module axis_pkt_rr_arbiter #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_IN             = 4
) (
    input  logic                                   clk,
    input  logic                                   aresetn,
    input  logic [NUM_IN*C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [NUM_IN*C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [NUM_IN*C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [NUM_IN-1:0]                      s_axis_tvalid,
    input  logic [NUM_IN-1:0]                      s_axis_tlast,
    output logic [NUM_IN-1:0]                      s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]         m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]          m_axis_tuser,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic [NUM_IN*32-1:0]                   pkt_cnt
);

    localparam int unsigned DW = C_AXIS_DATA_WIDTH;
    localparam int unsigned KW = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
    localparam int unsigned GW = $clog2(NUM_IN);
    localparam int unsigned CW = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last_grant;
    logic            r_first_beat;

    logic [GW-1:0]   w_rr_grant;
    logic [GW-1:0]   w_idx;
    logic            w_send;
    logic            w_xfer;
    logic [UW-1:0]   w_user;

    // Round-robin pick: first requester after r_last_grant, wrapping modulo NUM_IN
    always_comb begin
        w_rr_grant = r_last_grant;
        w_idx      = '0;
        for (int k = int'(NUM_IN); k >= 1; k--) begin
            w_idx = GW'((32'(r_last_grant) + 32'(k)) % NUM_IN);
            if (s_axis_tvalid[w_idx]) begin
                w_rr_grant = w_idx;
            end
        end
    end

    // Reset gates the handshakes so nothing moves while aresetn is low
    assign w_send        = (r_state == S_SEND) && aresetn;
    assign m_axis_tvalid = w_send && s_axis_tvalid[r_grant];
    assign w_xfer        = m_axis_tvalid && m_axis_tready;

    assign m_axis_tdata  = s_axis_tdata[32'(r_grant)*DW +: DW];
    assign m_axis_tkeep  = s_axis_tkeep[32'(r_grant)*KW +: KW];
    assign m_axis_tlast  = s_axis_tlast[r_grant];
    assign m_axis_tuser  = w_user;

    // Pass tuser through, stamping the source one-hot on the first beat
    always_comb begin
        w_user = s_axis_tuser[32'(r_grant)*UW +: UW];
        if (r_first_beat) begin
            w_user[23:16] = 8'(8'h01 << r_grant);
        end
    end

    // Only the granted input sees downstream ready
    always_comb begin
        s_axis_tready = '0;
        if (w_send) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the tlast transfer
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_IN - 1);
            r_first_beat <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|s_axis_tvalid) begin
                        r_grant      <= w_rr_grant;
                        r_state      <= S_SEND;
                        r_first_beat <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_first_beat <= 1'b0;
                        if (m_axis_tlast) begin
                            r_last_grant <= r_grant;
                            r_state      <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ARB_PKT_CNT_EN
    logic [CW-1:0] r_pkt_cnt [NUM_IN];

    // Count completed packets per input; wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_xfer && m_axis_tlast) begin
            r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + CW'(1);
        end
    end

    // Flatten the counters onto the output bus
    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            pkt_cnt[i*CW +: CW] = r_pkt_cnt[i];
        end
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule
